// File: rtl/sem_cmd_responder_if.sv
// Command/status bundle between a SEM-style command source and sem_cmd_responder.
interface sem_cmd_responder_if;
    logic        command_strobe;
    logic [43:0] command_code;
    logic        command_busy;
    logic        status_observation;
    logic        status_idle;
    logic        status_detect;
    logic        status_injection;
    logic        inject_valid;
    logic [17:0] inject_frame;
    logic [6:0]  inject_word;
    logic [4:0]  inject_bit;
    logic        cmd_error;
    logic        cmd_overrun;
    logic [15:0] cmd_count;

    modport master (
        output command_strobe, command_code,
        input  command_busy, status_observation, status_idle, status_detect,
               status_injection, inject_valid, inject_frame, inject_word,
               inject_bit, cmd_error, cmd_overrun, cmd_count
    );

    modport slave (
        input  command_strobe, command_code,
        output command_busy, status_observation, status_idle, status_detect,
               status_injection, inject_valid, inject_frame, inject_word,
               inject_bit, cmd_error, cmd_overrun, cmd_count
    );
endinterface

// File: rtl/sem_cmd_responder.sv
// Command responder: decodes mode/inject/soft-reset commands, times busy windows
// with one shared down-counter, and reports status, errors and overruns.
module sem_cmd_responder #(
    parameter int unsigned INIT_CYCLES   = 16,
    parameter int unsigned INJECT_CYCLES = 8,
    parameter int unsigned RESET_CYCLES  = 32
) (
    input logic                  clk,
    input logic                  resetn,
    sem_cmd_responder_if.slave   bus
);
    typedef enum logic [2:0] {
        S_INIT, S_OBSERVE, S_IDLE, S_DETECT, S_INJECT, S_SRESET, S_MODECHG
    } state_t;

    localparam logic [7:0] INIT_LOAD   = INIT_CYCLES[7:0];
    localparam logic [7:0] INJECT_LOAD = INJECT_CYCLES[7:0];
    localparam logic [7:0] RESET_LOAD  = RESET_CYCLES[7:0];
    localparam logic [7:0] MODE_LOAD   = 8'd2;

    state_t      state_q, state_d, target_q, target_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        inject_valid_q, inject_valid_d;
    logic        cmd_error_q, cmd_error_d;
    logic        cmd_overrun_q, cmd_overrun_d;
    logic [17:0] frame_q, frame_d;
    logic [6:0]  word_q, word_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] cmd_count_q, cmd_count_d;
    logic        accept;

    logic [3:0]  op;
    logic        rsv_zero;

    assign op       = bus.command_code[43:40];
    assign rsv_zero = (bus.command_code[39:32] == '0) && (bus.command_code[31:30] == '0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_INIT;
            target_q       <= S_OBSERVE;
            cnt_q          <= INIT_LOAD;
            busy_q         <= 1'b1;
            inject_valid_q <= 1'b0;
            cmd_error_q    <= 1'b0;
            cmd_overrun_q  <= 1'b0;
            frame_q        <= '0;
            word_q         <= '0;
            bit_q          <= '0;
            cmd_count_q    <= '0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            cnt_q          <= cnt_d;
            busy_q         <= busy_d;
            inject_valid_q <= inject_valid_d;
            cmd_error_q    <= cmd_error_d;
            cmd_overrun_q  <= cmd_overrun_d;
            frame_q        <= frame_d;
            word_q         <= word_d;
            bit_q          <= bit_d;
            cmd_count_q    <= cmd_count_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        cnt_d          = cnt_q;
        busy_d         = busy_q;
        inject_valid_d = 1'b0;
        cmd_error_d    = 1'b0;
        cmd_overrun_d  = 1'b0;
        frame_d        = frame_q;
        word_d         = word_q;
        bit_d          = bit_q;
        cmd_count_d    = cmd_count_q;
        accept         = 1'b0;

        if (busy_q) begin
            // Counter is loaded with the full duration; busy drops on the edge it reads 1.
            cmd_overrun_d = bus.command_strobe;
            if (cnt_q == 8'd1) begin
                busy_d = 1'b0;
                unique case (state_q)
                    S_INJECT:  state_d = S_IDLE;
                    S_MODECHG: state_d = target_q;
                    default:   state_d = S_OBSERVE;
                endcase
            end else begin
                cnt_d = cnt_q - 8'd1;
            end
        end else if (bus.command_strobe) begin
            if (rsv_zero) begin
                case (op)
                    4'hE, 4'hA, 4'hD: begin
                        accept  = 1'b1;
                        state_d = S_MODECHG;
                        cnt_d   = MODE_LOAD;
                        case (op)
                            4'hE:    target_d = S_IDLE;
                            4'hD:    target_d = S_DETECT;
                            default: target_d = S_OBSERVE;
                        endcase
                    end
                    4'hC: begin
                        if (state_q == S_IDLE) begin
                            accept         = 1'b1;
                            state_d        = S_INJECT;
                            cnt_d          = INJECT_LOAD;
                            inject_valid_d = 1'b1;
                            frame_d        = bus.command_code[29:12];
                            word_d         = bus.command_code[11:5];
                            bit_d          = bus.command_code[4:0];
                        end
                    end
                    4'hB: begin
                        accept  = 1'b1;
                        state_d = S_SRESET;
                        cnt_d   = RESET_LOAD;
                    end
                    default: ;
                endcase
            end
            if (accept) begin
                busy_d      = 1'b1;
                cmd_count_d = cmd_count_q + 16'd1;
            end else begin
                cmd_error_d = 1'b1;
            end
        end
    end

    assign bus.command_busy       = busy_q;
    assign bus.status_observation = (state_q == S_OBSERVE);
    assign bus.status_idle        = (state_q == S_IDLE);
    assign bus.status_detect      = (state_q == S_DETECT);
    assign bus.status_injection   = (state_q == S_INJECT);
    assign bus.inject_valid       = inject_valid_q;
    assign bus.inject_frame       = frame_q;
    assign bus.inject_word        = word_q;
    assign bus.inject_bit         = bit_q;
    assign bus.cmd_error          = cmd_error_q;
    assign bus.cmd_overrun        = cmd_overrun_q;
    assign bus.cmd_count          = cmd_count_q;
endmodule

// File: tb/tb_sem_cmd_responder.sv
// Directed bench for sem_cmd_responder: command table plus reset, overrun,
// abort and counter-wrap sequences.
module tb_sem_cmd_responder;
    localparam int unsigned INIT_CYCLES   = 16;
    localparam int unsigned INJECT_CYCLES = 8;
    localparam int unsigned RESET_CYCLES  = 32;

    localparam logic [3:0] F_NONE = 4'b0000;
    localparam logic [3:0] F_OBS  = 4'b1000;
    localparam logic [3:0] F_IDLE = 4'b0100;
    localparam logic [3:0] F_DET  = 4'b0010;
    localparam logic [3:0] F_INJ  = 4'b0001;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    sem_cmd_responder_if bus();

    sem_cmd_responder #(
        .INIT_CYCLES  (INIT_CYCLES),
        .INJECT_CYCLES(INJECT_CYCLES),
        .RESET_CYCLES (RESET_CYCLES)
    ) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    typedef struct {
        logic [43:0] code;
        logic        err;
        logic [3:0]  mid_flags;
        int          edges;
        logic [3:0]  end_flags;
        logic        inj;
        logic [17:0] frame;
        logic [6:0]  word;
        logic [4:0]  bitn;
    } vec_t;

    int compared = 0;
    int mismatched = 0;
    logic [15:0] exp_count;
    logic [17:0] exp_frame;
    logic [6:0]  exp_word;
    logic [4:0]  exp_bit;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {bus.status_observation, bus.status_idle, bus.status_detect, bus.status_injection};
    endfunction

    task automatic send(input logic [43:0] code);
        @(negedge clk);
        bus.command_code   = code;
        bus.command_strobe = 1'b1;
        @(negedge clk);
        bus.command_strobe = 1'b0;
    endtask

    // Edges from the strobe edge until busy is seen low, and inject pulses seen meanwhile.
    task automatic wait_not_busy(output int edges, output int pulses);
        edges  = 1;
        pulses = int'(bus.inject_valid);
        while (bus.command_busy && edges < 200) begin
            @(negedge clk);
            edges++;
            pulses += int'(bus.inject_valid);
        end
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_busy"}, bus.command_busy, 1'b1);
        chk({tag, "_flags"}, flags(), F_NONE);
        chk({tag, "_count"}, bus.cmd_count, 16'h0);
        chk({tag, "_pulses"}, {bus.inject_valid, bus.cmd_error, bus.cmd_overrun}, 3'b000);
        chk({tag, "_fields"}, {bus.inject_frame, bus.inject_word, bus.inject_bit}, 30'h0);
    endtask

    task automatic init_phase(input bit poke);
        int e;
        @(negedge clk);
        resetn = 1'b1;
        e = 0;
        while (bus.command_busy && e < 200) begin
            if (poke && e == 5) begin
                bus.command_code   = 44'hA00_0000_0000;
                bus.command_strobe = 1'b1;
            end
            @(negedge clk);
            e++;
            if (poke && e == 6) begin
                bus.command_strobe = 1'b0;
                chk("init_overrun", bus.cmd_overrun, 1'b1);
                chk("init_overrun_no_err", bus.cmd_error, 1'b0);
            end
        end
        chk("init_busy_edges", e, INIT_CYCLES);
        chk("init_flags", flags(), F_OBS);
        chk("init_count", bus.cmd_count, 16'h0);
    endtask

    vec_t vecs[13];

    initial begin
        int e, p;
        bus.command_strobe = 1'b0;
        bus.command_code   = '0;
        exp_count = '0;
        exp_frame = '0;
        exp_word  = '0;
        exp_bit   = '0;

        vecs[0]  = '{44'hE00_3FFFF_000, 1'b0, F_NONE, 3,  F_IDLE, 1'b0, 18'h0,     7'h0,  5'h0};
        vecs[1]  = '{44'hC00_0012_3456, 1'b0, F_INJ,  9,  F_IDLE, 1'b1, 18'h00123, 7'h22, 5'h16};
        vecs[2]  = '{44'hA01_0000_0000, 1'b1, F_NONE, 1,  F_IDLE, 1'b0, 18'h0,     7'h0,  5'h0};
        vecs[3]  = '{44'hF00_0000_0000, 1'b1, F_NONE, 1,  F_IDLE, 1'b0, 18'h0,     7'h0,  5'h0};
        vecs[4]  = '{44'hE00_4000_0000, 1'b1, F_NONE, 1,  F_IDLE, 1'b0, 18'h0,     7'h0,  5'h0};
        vecs[5]  = '{44'hD00_0000_0000, 1'b0, F_NONE, 3,  F_DET,  1'b0, 18'h0,     7'h0,  5'h0};
        vecs[6]  = '{44'hC00_0000_0001, 1'b1, F_NONE, 1,  F_DET,  1'b0, 18'h0,     7'h0,  5'h0};
        vecs[7]  = '{44'hA00_0000_0000, 1'b0, F_NONE, 3,  F_OBS,  1'b0, 18'h0,     7'h0,  5'h0};
        vecs[8]  = '{44'hC00_0012_3456, 1'b1, F_NONE, 1,  F_OBS,  1'b0, 18'h0,     7'h0,  5'h0};
        vecs[9]  = '{44'hE00_0000_0000, 1'b0, F_NONE, 3,  F_IDLE, 1'b0, 18'h0,     7'h0,  5'h0};
        vecs[10] = '{44'hC00_3FFF_FFFF, 1'b0, F_INJ,  9,  F_IDLE, 1'b1, 18'h3FFFF, 7'h7F, 5'h1F};
        vecs[11] = '{44'h700_0000_0000, 1'b1, F_NONE, 1,  F_IDLE, 1'b0, 18'h0,     7'h0,  5'h0};
        vecs[12] = '{44'hB00_0000_0000, 1'b0, F_NONE, 33, F_OBS,  1'b0, 18'h0,     7'h0,  5'h0};

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        init_phase(1'b1);

        foreach (vecs[i]) begin
            send(vecs[i].code);
            chk($sformatf("v%0d_error", i), bus.cmd_error, vecs[i].err);
            chk($sformatf("v%0d_overrun", i), bus.cmd_overrun, 1'b0);
            if (vecs[i].edges > 1)
                chk($sformatf("v%0d_mid_flags", i), flags(), vecs[i].mid_flags);
            if (vecs[i].inj) begin
                exp_frame = vecs[i].frame;
                exp_word  = vecs[i].word;
                exp_bit   = vecs[i].bitn;
            end
            wait_not_busy(e, p);
            chk($sformatf("v%0d_busy_edges", i), e, vecs[i].edges);
            chk($sformatf("v%0d_inject_pulses", i), p, int'(vecs[i].inj));
            chk($sformatf("v%0d_end_flags", i), flags(), vecs[i].end_flags);
            if (!vecs[i].err) exp_count++;
            chk($sformatf("v%0d_count", i), bus.cmd_count, exp_count);
            chk($sformatf("v%0d_fields", i), {bus.inject_frame, bus.inject_word, bus.inject_bit},
                {exp_frame, exp_word, exp_bit});
        end

        // Overrun in the middle of an injection window.
        send(44'hE00_0000_0000);
        wait_not_busy(e, p);
        send(44'hC00_0000_0021);
        chk("ovr_inject_valid", bus.inject_valid, 1'b1);
        chk("ovr_inject_fields", {bus.inject_frame, bus.inject_word, bus.inject_bit},
            {18'h0, 7'h01, 5'h01});
        repeat (2) @(negedge clk);
        send(44'hA00_0000_0000);
        chk("ovr_pulse", bus.cmd_overrun, 1'b1);
        chk("ovr_no_error", bus.cmd_error, 1'b0);
        chk("ovr_still_inject", flags(), F_INJ);
        wait_not_busy(e, p);
        chk("ovr_total_edges", 4 + e, INJECT_CYCLES + 1);
        chk("ovr_end_flags", flags(), F_IDLE);
        exp_count += 16'd2;
        chk("ovr_count", bus.cmd_count, exp_count);
        chk("ovr_fields_hold", {bus.inject_frame, bus.inject_word, bus.inject_bit},
            {18'h0, 7'h01, 5'h01});

        // Soft reset from DETECT, aborted by resetn partway through.
        send(44'hD00_0000_0000);
        wait_not_busy(e, p);
        chk("sr_detect", flags(), F_DET);
        send(44'hB00_0000_0000);
        chk("sr_flags_low", flags(), F_NONE);
        chk("sr_busy", bus.command_busy, 1'b1);
        repeat (9) @(negedge clk);
        chk("sr_busy_cycle10", bus.command_busy, 1'b1);
        #2 resetn = 1'b0;
        #1 check_reset_values("abort");
        exp_count = '0;
        init_phase(1'b0);

        // Counter wrap, with the count preloaded to just below the top.
        @(negedge clk);
        force dut.cmd_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.cmd_count_q;
        @(negedge clk);
        chk("wrap_preload", bus.cmd_count, 16'hFFFE);
        send(44'hE00_0000_0000);
        wait_not_busy(e, p);
        chk("wrap_ffff", bus.cmd_count, 16'hFFFF);
        send(44'hA00_0000_0000);
        wait_not_busy(e, p);
        chk("wrap_zero", bus.cmd_count, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1_000_000;
        mismatched++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "timeout");
    end
endmodule
